// File: rtl/tim1_sr_ctrl.sv
// TIM1 status-flag sequencer: turns hardware event pulses and write-0-to-clear
// accesses into SETUP/STROBE/HOLD load or clear strobes for the flag cells.

module tim1_sr_chan #(
   parameter int PULSE_W = 1
) (
   input  logic clk,
   input  logic rst_isr,
   input  logic i_evt,
   input  logic i_clr_wr,
   output logic o_ld,
   output logic o_rst_strobe,
   output logic o_data,
   output logic o_busy
);
   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

   localparam logic [3:0] LP_CNT_INIT = 4'(PULSE_W - 1);

   state_t     r_state;
   logic       r_op_set;
   logic       r_pend_set;
   logic       r_pend_clr;
   logic [3:0] r_cnt;
   logic       r_ld;
   logic       r_rst;
   logic       r_data;
   logic       r_busy;

   logic       w_set_req;
   logic       w_clr_req;

   assign w_set_req = i_evt | r_pend_set;
   assign w_clr_req = i_clr_wr | r_pend_clr;

   always_ff @(posedge clk or posedge rst_isr) begin
      if (rst_isr) begin
         r_state    <= S_IDLE;
         r_op_set   <= 1'b0;
         r_pend_set <= 1'b0;
         r_pend_clr <= 1'b0;
         r_cnt      <= 4'd0;
         r_ld       <= 1'b0;
         r_rst      <= 1'b0;
         r_data     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_set_req) begin
                  r_op_set   <= 1'b1;
                  r_state    <= S_SETUP;
                  r_data     <= 1'b1;
                  r_busy     <= 1'b1;
                  // a fresh event alongside a pending set is kept for the next pass
                  r_pend_set <= r_pend_set & i_evt;
                  r_pend_clr <= 1'b0;
               end else if (w_clr_req) begin
                  r_op_set   <= 1'b0;
                  r_state    <= S_SETUP;
                  r_data     <= 1'b1;
                  r_busy     <= 1'b1;
                  r_pend_clr <= 1'b0;
               end
            end
            S_SETUP: begin
               r_state <= S_STROBE;
               r_cnt   <= LP_CNT_INIT;
               r_ld    <= r_op_set;
               r_rst   <= ~r_op_set;
            end
            S_STROBE: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_HOLD;
                  r_ld    <= 1'b0;
                  r_rst   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_HOLD: begin
               r_state <= S_IDLE;
               r_data  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase

         // requests seen while busy are remembered, repeated ones merge
         if (r_state != S_IDLE) begin
            if (i_evt)    r_pend_set <= 1'b1;
            if (i_clr_wr) r_pend_clr <= 1'b1;
         end
      end
   end

   assign o_ld         = r_ld;
   assign o_rst_strobe = r_rst;
   assign o_data       = r_data;
   assign o_busy       = r_busy;
endmodule

module tim1_sr_ctrl #(
   parameter int PULSE_W = 1
) (
   input  logic       clk,
   input  logic       rst_isr,
   input  logic       uif_evt,
   input  logic       cc1if_evt,
   input  logic       sr_wr,
   input  logic [1:0] sr_wdata,
   input  logic       dier_uie,
   input  logic       dier_cc1ie,
   input  logic       o_uif,
   input  logic       o_cc1if,
   output logic       ld_sr_uif,
   output logic       ld_sr_cc1if,
   output logic       i_uif,
   output logic       i_cc1if,
   output logic       rst_uif,
   output logic       rst_cc1if,
   output logic [1:0] busy,
   output logic       irq
);
   logic w_uif_clr;
   logic w_cc1_clr;
   logic w_uif_rst_strobe;
   logic w_cc1_rst_strobe;
   logic r_irq;

   assign w_uif_clr = sr_wr & ~sr_wdata[0];
   assign w_cc1_clr = sr_wr & ~sr_wdata[1];

   tim1_sr_chan #(.PULSE_W(PULSE_W)) u_uif (
      .clk          (clk),
      .rst_isr      (rst_isr),
      .i_evt        (uif_evt),
      .i_clr_wr     (w_uif_clr),
      .o_ld         (ld_sr_uif),
      .o_rst_strobe (w_uif_rst_strobe),
      .o_data       (i_uif),
      .o_busy       (busy[0])
   );

   tim1_sr_chan #(.PULSE_W(PULSE_W)) u_cc1 (
      .clk          (clk),
      .rst_isr      (rst_isr),
      .i_evt        (cc1if_evt),
      .i_clr_wr     (w_cc1_clr),
      .o_ld         (ld_sr_cc1if),
      .o_rst_strobe (w_cc1_rst_strobe),
      .o_data       (i_cc1if),
      .o_busy       (busy[1])
   );

   // flag cells must also clear while the block itself is in reset
   assign rst_uif   = rst_isr | w_uif_rst_strobe;
   assign rst_cc1if = rst_isr | w_cc1_rst_strobe;

   always_ff @(posedge clk or posedge rst_isr) begin
      if (rst_isr) r_irq <= 1'b0;
      else         r_irq <= (o_uif & dier_uie) | (o_cc1if & dier_cc1ie);
   end

   assign irq = r_irq;
endmodule

// File: tb/tb_tim1_sr_ctrl.sv
// Bench for tim1_sr_ctrl: two instances (PULSE_W 1 and 4) with flag-cell models,
// compared every cycle against a phase-counting reference model.

module tb_tim1_sr_ctrl;
   logic        clk        = 1'b0;
   logic        rst_isr    = 1'b1;
   logic        uif_evt    = 1'b0;
   logic        cc1if_evt  = 1'b0;
   logic        sr_wr      = 1'b0;
   logic [1:0]  sr_wdata   = 2'b11;
   logic        dier_uie   = 1'b0;
   logic        dier_cc1ie = 1'b0;

   logic [21:0] got_all;
   logic [21:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   // reference model: per instance k, channel c (0 UIF, 1 CC1IF)
   int          pw_of [2] = '{1, 4};
   int          ph    [2][2];
   bit          opset [2][2];
   bit          pset  [2][2];
   bit          pclr  [2][2];
   bit          flg   [2][2];
   bit          irq_m [2];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs + flag cells ----------------
   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int PW = (g == 0) ? 1 : 4;
      logic       ldu, ldc, iu, ic, rsu, rsc, irq_o;
      logic [1:0] busy_o;
      logic       flu = 1'b0;
      logic       flc = 1'b0;
      int         ldu_cnt = 0;
      int         rsu_cnt = 0;

      tim1_sr_ctrl #(.PULSE_W(PW)) u_dut (
         .clk         (clk),
         .rst_isr     (rst_isr),
         .uif_evt     (uif_evt),
         .cc1if_evt   (cc1if_evt),
         .sr_wr       (sr_wr),
         .sr_wdata    (sr_wdata),
         .dier_uie    (dier_uie),
         .dier_cc1ie  (dier_cc1ie),
         .o_uif       (flu),
         .o_cc1if     (flc),
         .ld_sr_uif   (ldu),
         .ld_sr_cc1if (ldc),
         .i_uif       (iu),
         .i_cc1if     (ic),
         .rst_uif     (rsu),
         .rst_cc1if   (rsc),
         .busy        (busy_o),
         .irq         (irq_o)
      );

      always @(posedge ldu or posedge rsu) if (rsu) flu <= 1'b0; else flu <= iu;
      always @(posedge ldc or posedge rsc) if (rsc) flc <= 1'b0; else flc <= ic;
      always @(posedge ldu) ldu_cnt++;
      always @(posedge rsu) rsu_cnt++;

      assign got_all[g*11 +: 11] = {flc, flu, irq_o, busy_o, rsc, rsu, ic, iu, ldc, ldu};
   end

   // ---------------- reference model ----------------
   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         irq_m[k] = 1'b0;
         for (int c = 0; c < 2; c++) begin
            ph[k][c] = -1; opset[k][c] = 1'b0; pset[k][c] = 1'b0;
            pclr[k][c] = 1'b0; flg[k][c] = 1'b0;
         end
      end
   endfunction

   // ph = cycles since the operation started: 0 setup, 1..PW strobe, PW+1 hold
   function automatic void mstep(int k, int c, bit ev, bit cl);
      if (ph[k][c] < 0) begin
         if (ev || pset[k][c]) begin
            opset[k][c] = 1'b1; ph[k][c] = 0;
            pset[k][c] = pset[k][c] && ev; pclr[k][c] = 1'b0;
         end else if (cl || pclr[k][c]) begin
            opset[k][c] = 1'b0; ph[k][c] = 0; pclr[k][c] = 1'b0;
         end
      end else begin
         if (ev) pset[k][c] = 1'b1;
         if (cl) pclr[k][c] = 1'b1;
         ph[k][c]++;
         if (ph[k][c] == 1) flg[k][c] = opset[k][c];
         if (ph[k][c] > pw_of[k] + 1) ph[k][c] = -1;
      end
   endfunction

   function automatic logic [21:0] pack_exp();
      logic [21:0] v;
      bit b, st;
      v = '0;
      for (int k = 0; k < 2; k++) begin
         v[k*11 + 8] = irq_m[k];
         for (int c = 0; c < 2; c++) begin
            b  = (ph[k][c] >= 0);
            st = (ph[k][c] >= 1) && (ph[k][c] <= pw_of[k]);
            v[k*11 + c]     = st && opset[k][c];
            v[k*11 + 2 + c] = b;
            v[k*11 + 4 + c] = (st && !opset[k][c]) || rst_isr;
            v[k*11 + 6 + c] = b;
            v[k*11 + 9 + c] = flg[k][c];
         end
      end
      return v;
   endfunction

   always @(posedge clk or posedge rst_isr) begin
      if (rst_isr) begin
         model_reset();
      end else begin
         for (int k = 0; k < 2; k++) begin
            irq_m[k] = (flg[k][0] && dier_uie) || (flg[k][1] && dier_cc1ie);
            mstep(k, 0, uif_evt,   sr_wr && !sr_wdata[0]);
            mstep(k, 1, cc1if_evt, sr_wr && !sr_wdata[1]);
         end
      end
      exp_q.push_back(pack_exp());
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      logic [21:0] e;
      @(negedge clk);
      chk("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q[$];
         exp_q.delete();
         chk("dut_pw1", 32'(got_all[10:0]),  32'(e[10:0]));
         chk("dut_pw4", 32'(got_all[21:11]), 32'(e[21:11]));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic ue, input logic ce, input logic wr, input logic [1:0] wd);
      uif_evt = ue; cc1if_evt = ce; sr_wr = wr; sr_wdata = wd;
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, 2'b11);
   endtask

   task automatic mid_reset();
      uif_evt = 1'b0; cc1if_evt = 1'b0; sr_wr = 1'b0; sr_wdata = 2'b11;
      @(posedge clk);
      #2 rst_isr = 1'b1;
      tick();
      chk("mid_rst_uif", 32'(got_all[4]), 32'd1);
      tick();
      rst_isr = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c0, c1, r0;

      repeat (3) begin
         tick();
         chk("rst_hold_uif", 32'(got_all[4]),  32'd1);
         chk("rst_hold_cc1", 32'(got_all[16]), 32'd1);
      end
      rst_isr = 1'b0;
      idle(2);
      dier_uie = 1'b1; dier_cc1ie = 1'b1;

      c0 = g_dut[0].ldu_cnt;
      cyc(1'b1, 1'b0, 1'b0, 2'b11);
      idle(6);
      chk("uif_set_pulses", 32'(g_dut[0].ldu_cnt - c0), 32'd1);
      chk("uif_flag_set",   32'(got_all[9]), 32'd1);

      cyc(1'b0, 1'b0, 1'b1, 2'b10);
      idle(8);
      chk("uif_flag_clr", 32'(got_all[9]), 32'd0);
      chk("irq_after_clr", 32'(got_all[8]), 32'd0);

      r0 = g_dut[0].rsu_cnt;
      cyc(1'b1, 1'b0, 1'b1, 2'b10);
      idle(8);
      chk("set_wins_no_rst", 32'(g_dut[0].rsu_cnt - r0), 32'd0);
      chk("set_wins_flag",   32'(got_all[9]),  32'd1);
      chk("set_wins_flag4",  32'(got_all[20]), 32'd1);

      cyc(1'b0, 1'b1, 1'b0, 2'b11);
      idle(8);
      cyc(1'b0, 1'b0, 1'b1, 2'b01);
      idle(1);
      cyc(1'b0, 1'b1, 1'b0, 2'b11);
      idle(16);
      chk("cc1_final_pw1", 32'(got_all[10]), 32'd1);
      chk("cc1_final_pw4", 32'(got_all[21]), 32'd1);

      c0 = g_dut[0].ldu_cnt; c1 = g_dut[1].ldu_cnt;
      cyc(1'b1, 1'b0, 1'b0, 2'b11);
      idle(1);
      cyc(1'b1, 1'b0, 1'b0, 2'b11);
      cyc(1'b1, 1'b0, 1'b0, 2'b11);
      idle(20);
      chk("merge_pulses_pw1", 32'(g_dut[0].ldu_cnt - c0), 32'd2);
      chk("merge_pulses_pw4", 32'(g_dut[1].ldu_cnt - c1), 32'd2);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            mid_reset();
         end else begin
            if ($urandom_range(0, 31) == 0) begin
               dier_uie   = 1'($urandom_range(0, 1));
               dier_cc1ie = 1'($urandom_range(0, 1));
            end
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)));
         end
      end
      idle(10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
